uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller between the UART receiver and the system bus. Watches the receiver's sticky ready/error flags, captures each word, issues one-cycle ready/error clear pulses back to the receiver, drops words flagged as framing errors, and buffers good words in a small FIFO. Words leave the FIFO on a valid/ready stream to the consumer. Overruns and errors are reported as status outputs.

## Interface
- DATA_WIDTH, 8, word width; must match the receiver.
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the level output (derived).
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_data_rdy_i  in  1  receiver sticky data-ready.
- rx_data_err_i  in  1  receiver sticky data-error.
- rx_data_i  in  DATA_WIDTH  receiver output word.
- rx_data_rdy_clr_o  out  1  ready-clear pulse to the receiver.
- rx_data_err_clr_o  out  1  error-clear pulse to the receiver.
- m_data_o  out  DATA_WIDTH  FIFO head word.
- m_valid_o  out  1  FIFO not empty.
- m_ready_i  in  1  consumer accepts the head word.
- flush_i  in  1  synchronous FIFO flush.
- fifo_level_o  out  LVL_W  current entry count.
- overrun_o  out  1  sticky: a good word was lost because the FIFO was full.
- overrun_clr_i  in  1  clears overrun_o.
- err_cnt_o  out  8  saturating framing-error count (see Configuration).

## Operation
- FSM states, in a package enum: RXC_IDLE, RXC_CAPTURE, RXC_ERR_CLR, RXC_SETTLE.
- From RXC_IDLE:
  - rx_data_err_i=1 → RXC_ERR_CLR. Error takes priority when both flags are high.
  - else rx_data_rdy_i=1 → RXC_CAPTURE.
  - else stay in RXC_IDLE.
- RXC_ERR_CLR:
  - rx_data_err_clr_o=1 for this cycle.
  - drop_q←1.
  - err_cnt+1, saturating at 255.
  - → RXC_SETTLE.
- RXC_CAPTURE:
  - rx_data_rdy_clr_o=1 for this cycle.
  - If drop_q=1: discard rx_data_i and set drop_q←0.
  - Else if the FIFO is not full, or a pop occurs this cycle: push rx_data_i.
  - Else: discard rx_data_i and set overrun_o←1.
  - → RXC_SETTLE.
- RXC_SETTLE: unconditional → RXC_IDLE. This gives the receiver one edge to drop its flag, so a stale level is never re-sampled.
- Clear pulses are Moore decodes of the state register: exactly one cycle each, never both high together.
- FIFO behaviour:
  - First-word fall-through.
  - m_valid_o = (level≠0); m_data_o = head entry.
  - Pop when m_valid_o & m_ready_i.
  - Push and pop in the same cycle: both happen, level unchanged, including when full.
  - m_ready_i while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; level saturates at neither end because overrun/empty are guarded.
- flush_i:
  - Sets level to 0 and pointers to 0.
  - Clears drop_q.
  - Wins over a same-cycle push or pop; the pushed word is lost, without an overrun.
  - FSM state is unaffected.
- overrun_o: set has priority over overrun_clr_i in the same cycle.
- Unreachable FSM encodings → RXC_IDLE.

## Timing
- Reset values:
  - State RXC_IDLE.
  - drop_q=0, level=0, m_valid_o=0, m_data_o=0.
  - Both clear pulses 0.
  - overrun_o=0, err_cnt_o=0.
- Word path, with rx_data_rdy_i sampled high at edge N:
  - CAPTURE during N+1.
  - m_valid_o=1 from N+2 (if the FIFO was empty).
  - FSM back in IDLE at N+3.
- Minimum service interval: 3 cycles per receiver event.
- Error sequence: the receiver raises its error flag one cycle before its ready flag. The controller handles ERR_CLR, SETTLE, then IDLE sees ready, and CAPTURE drops that word. The error word never reaches the FIFO.
- Reset asserted mid-sequence: all state returns to reset values immediately (asynchronous). An in-flight word is lost; the receiver flags remain set and are serviced after reset release.

## Configuration
- UART_RX_CTRL_ERR_CNT_EN defined: 8-bit saturating error counter is built and drives err_cnt_o.
- Undefined: no counter logic; err_cnt_o tied to 0.
- Error drop/clear behaviour is identical in both builds.

## Structure
- UART_pkg holds:
  - the enum uart_rx_ctrl_e (RXC_IDLE, RXC_CAPTURE, RXC_ERR_CLR, RXC_SETTLE);
  - the constant ERR_CNT_MAX=8'hFF.
- Sub-module uart_sync_fifo (DATA_WIDTH, FIFO_DEPTH):
  - push/pop/flush inputs;
  - full/empty/level outputs;
  - FWFT head;
  - same clock and reset.

## Test plan
- Reset, then receiver emits 0xA5 → one rx_data_rdy_clr_o pulse; m_valid_o=1 with m_data_o=0xA5 two cycles after ready; m_ready_i=1 → level 0.
- Error then ready (word 0x3C) → one err clr pulse then one rdy clr pulse; FIFO stays empty; err_cnt_o=1 with the macro, 0 without.
- With m_ready_i=0, push 5 words 0x01..0x05 into a depth-4 FIFO → level=4, overrun_o=1, head=0x01; overrun_clr_i → overrun_o=0.
- FIFO full and a new word arriving with m_ready_i=1 in the CAPTURE cycle → push and pop both happen; level stays 4; overrun_o stays 0.
- flush_i in the same cycle as a CAPTURE push of 0x77 → level=0, m_valid_o=0, overrun_o=0.
- Assert rst_i during RXC_SETTLE → every output returns to its reset value; a ready flag still held high after release is captured normally.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and constants for the UART receive controller
package uart_pkg;

  typedef enum logic [1:0] {
    RXC_IDLE    = 2'd0,
    RXC_CAPTURE = 2'd1,
    RXC_ERR_CLR = 2'd2,
    RXC_SETTLE  = 2'd3
  } uart_rx_ctrl_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through synchronous FIFO with flush
// Push is accepted when full only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [LVL_W-1:0]      level_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic                  push_en;
  logic                  pop_en;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage is reset so the head word reads 0 out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_en && !pop_en) level_q <= level_q + 1'b1;
      else if (pop_en && !push_en) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - services UART receiver flags, drops errored words, buffers good ones
// Optional error counter built when UART_RX_CTRL_ERR_CNT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_data_rdy_i,
  input  logic                  rx_data_err_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  rx_data_rdy_clr_o,
  output logic                  rx_data_err_clr_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  input  logic                  flush_i,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i,
  output logic [7:0]            err_cnt_o
);

  uart_rx_ctrl_e state_q, state_d;
  logic          drop_q;
  logic          overrun_q;
  logic          capture;
  logic          push;
  logic          pop;
  logic          lost;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RXC_IDLE;
    else       state_q <= state_d;
  end

  // SETTLE gives the receiver an edge to drop its flag before IDLE samples again.
  always_comb begin
    state_d           = state_q;
    rx_data_rdy_clr_o = 1'b0;
    rx_data_err_clr_o = 1'b0;
    case (state_q)
      RXC_IDLE: begin
        if (rx_data_err_i)      state_d = RXC_ERR_CLR;
        else if (rx_data_rdy_i) state_d = RXC_CAPTURE;
      end
      RXC_CAPTURE: begin
        rx_data_rdy_clr_o = 1'b1;
        state_d           = RXC_SETTLE;
      end
      RXC_ERR_CLR: begin
        rx_data_err_clr_o = 1'b1;
        state_d           = RXC_SETTLE;
      end
      RXC_SETTLE: state_d = RXC_IDLE;
      default:    state_d = RXC_IDLE;
    endcase
  end

  assign capture   = (state_q == RXC_CAPTURE);
  assign pop       = ~fifo_empty & m_ready_i;
  assign push      = capture & ~drop_q & (~fifo_full | pop);
  assign lost      = capture & ~drop_q & fifo_full & ~pop & ~flush_i;
  assign m_valid_o = ~fifo_empty;
  assign overrun_o = overrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (flush_i)                    drop_q <= 1'b0;
      else if (state_q == RXC_ERR_CLR) drop_q <= 1'b1;
      else if (capture)               drop_q <= 1'b0;
      if (lost)               overrun_q <= 1'b1;
      else if (overrun_clr_i) overrun_q <= 1'b0;
    end
  end

`ifdef UART_RX_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= 8'd0;
    else if (state_q == RXC_ERR_CLR && err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'd0;
`endif

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (rx_data_i),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_o  (m_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

endmodule
